// File: rtl/clk_rst_seq.sv
// clk_rst_seq: PLL bring-up sequencer and chip reset supervisor.
// Runs on the raw reference clock and holds the PLL in reset for a fixed window.
// It waits for lock with a timeout and retries a bounded number of times.
// Lock must stay stable for a qualification window before chip reset is released.
// Lock loss while running, and retry exhaustion, are reported with sticky flags.
//
// Interface notes:
//  - i_reset asserts asynchronously. It is expected to be released synchronously
//    to i_clk_ref by the board-level reset logic.
//  - i_locked is asynchronous to i_clk_ref and is passed through a 2-flop
//    synchroniser before the FSM uses it.
//  - i_sw_rst_req is a single-cycle request sampled on i_clk_ref, with no
//    acknowledge. Whenever it is high it takes precedence over every other
//    transition.
//  - Every output is a register that is updated in the same cycle as the state
//    register. o_seq_state therefore always matches the other outputs.
module clk_rst_seq #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int STABLE_CYCLES  = 1024,
    parameter int MAX_RETRY      = 7,
    parameter int CNT_W          = 17,
    parameter int RETRY_W        = 3
) (
    input  logic               i_clk_ref,
    input  logic               i_reset,
    input  logic               i_locked,
    input  logic               i_sw_rst_req,
    output logic               o_pll_areset,
    output logic               o_chip_reset,
    output logic               o_lock_fail,
    output logic               o_lock_lost,
    output logic [RETRY_W-1:0] o_retry_cnt,
    output logic [2:0]         o_seq_state
);

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } seq_state_t;

    // Terminal counts. The counter starts at 0 in every state, so the last
    // count of each window is the cycle count minus one.
    localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRY);

    seq_state_t         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [RETRY_W-1:0] r_retry_cnt;
    logic               r_pll_areset;
    logic               r_chip_reset;
    logic               r_lock_fail;
    logic               r_lock_lost;
    logic [1:0]         r_locked_sync;
    logic               w_locked_s;

    assign w_locked_s = r_locked_sync[1];

    // Two-flop synchroniser bringing the PLL lock indication into the clk_ref domain
    always_ff @(posedge i_clk_ref or posedge i_reset) begin
        if (i_reset) begin
            r_locked_sync <= 2'b00;
        end else begin
            r_locked_sync <= {r_locked_sync[0], i_locked};
        end
    end

    // Sequencer FSM with registered outputs; cnt is cleared on every state change
    always_ff @(posedge i_clk_ref or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= ST_PLL_RST;
            r_cnt        <= '0;
            r_retry_cnt  <= '0;
            r_pll_areset <= 1'b1;
            r_chip_reset <= 1'b1;
            r_lock_fail  <= 1'b0;
            r_lock_lost  <= 1'b0;
        end else if (i_sw_rst_req) begin
            // A software restart overrides any timeout or lock loss in the same
            // cycle. It also restarts a PLL reset window that is already running.
            r_state      <= ST_PLL_RST;
            r_cnt        <= '0;
            r_retry_cnt  <= '0;
            r_pll_areset <= 1'b1;
            r_chip_reset <= 1'b1;
            r_lock_fail  <= 1'b0;
            r_lock_lost  <= 1'b0;
        end else begin
            case (r_state)
                ST_PLL_RST: begin
                    if (r_cnt == RST_LAST) begin
                        r_state      <= ST_WAIT_LOCK;
                        r_cnt        <= '0;
                        r_pll_areset <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (w_locked_s) begin
                        // If lock arrives on the timeout cycle, lock wins.
                        r_state <= ST_STABLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == LOCK_LAST) begin
                        r_cnt        <= '0;
                        r_pll_areset <= 1'b1;
                        if (r_retry_cnt < RETRY_MAX) begin
                            r_state     <= ST_PLL_RST;
                            r_retry_cnt <= r_retry_cnt + 1'b1;
                        end else begin
                            r_state     <= ST_FAIL;
                            r_lock_fail <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_STABLE: begin
                    if (!w_locked_s) begin
                        // A lock glitch opens a fresh timeout window. No retry is consumed.
                        r_state <= ST_WAIT_LOCK;
                        r_cnt   <= '0;
                    end else if (r_cnt == STABLE_LAST) begin
                        r_state      <= ST_RUN;
                        r_cnt        <= '0;
                        r_retry_cnt  <= '0;
                        r_chip_reset <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!w_locked_s) begin
                        r_state      <= ST_PLL_RST;
                        r_cnt        <= '0;
                        r_pll_areset <= 1'b1;
                        r_chip_reset <= 1'b1;
                        r_lock_lost  <= 1'b1;
                    end
                end
                ST_FAIL: begin
                    // Parked with the PLL held in reset until reset or sw_rst_req.
                    r_cnt        <= '0;
                    r_pll_areset <= 1'b1;
                    r_chip_reset <= 1'b1;
                    r_lock_fail  <= 1'b1;
                end
                default: begin
                    // An unused state code falls back to a full bring-up.
                    r_state      <= ST_PLL_RST;
                    r_cnt        <= '0;
                    r_pll_areset <= 1'b1;
                    r_chip_reset <= 1'b1;
                end
            endcase
        end
    end

    assign o_pll_areset = r_pll_areset;
    assign o_chip_reset = r_chip_reset;
    assign o_lock_fail  = r_lock_fail;
    assign o_lock_lost  = r_lock_lost;
    assign o_retry_cnt  = r_retry_cnt;
    assign o_seq_state  = r_state;

endmodule

// File: tb/tb_clk_rst_seq.sv
// tb_clk_rst_seq: directed bench for the PLL bring-up sequencer.
// The sequencer uses small parameters so whole sequences fit in a few hundred cycles.
// Tick numbers in the comments count posedges since the last reset release or event.
module tb_clk_rst_seq;

    localparam int PLL_RST_CYCLES = 4;
    localparam int LOCK_TIMEOUT   = 32;
    localparam int STABLE_CYCLES  = 8;
    localparam int MAX_RETRY      = 2;
    localparam int CNT_W          = 17;
    localparam int RETRY_W        = 3;

    logic               i_clk_ref;
    logic               i_reset;
    logic               i_locked;
    logic               i_sw_rst_req;
    logic               o_pll_areset;
    logic               o_chip_reset;
    logic               o_lock_fail;
    logic               o_lock_lost;
    logic [RETRY_W-1:0] o_retry_cnt;
    logic [2:0]         o_seq_state;

    int err_cnt = 0;
    int chk_cnt = 0;
    logic [15:0] exp_q[$];

    clk_rst_seq #(
        .PLL_RST_CYCLES(PLL_RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .STABLE_CYCLES (STABLE_CYCLES),
        .MAX_RETRY     (MAX_RETRY),
        .CNT_W         (CNT_W),
        .RETRY_W       (RETRY_W)
    ) dut (
        .i_clk_ref   (i_clk_ref),
        .i_reset     (i_reset),
        .i_locked    (i_locked),
        .i_sw_rst_req(i_sw_rst_req),
        .o_pll_areset(o_pll_areset),
        .o_chip_reset(o_chip_reset),
        .o_lock_fail (o_lock_fail),
        .o_lock_lost (o_lock_lost),
        .o_retry_cnt (o_retry_cnt),
        .o_seq_state (o_seq_state)
    );

    // Clock and reset
    initial i_clk_ref = 1'b0;
    always #5 i_clk_ref = ~i_clk_ref;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One cycle: outputs are sampled and inputs are driven 1 time unit after the posedge.
    task automatic tick();
        @(posedge i_clk_ref);
        #1;
    endtask

    // Holds reset for a few cycles, then releases it just after a posedge (tick 0).
    task automatic apply_reset();
        i_reset      = 1'b1;
        i_locked     = 1'b0;
        i_sw_rst_req = 1'b0;
        repeat (3) tick();
        i_reset = 1'b0;
    endtask

    task automatic test_reset();
        i_reset      = 1'b1;
        i_locked     = 1'b0;
        i_sw_rst_req = 1'b0;
        repeat (2) tick();
        chk_cnt++; if (o_seq_state !== 3'd0) begin err_cnt++; $display("FAIL reset_state: got %0d exp 0", o_seq_state); end
        chk_cnt++; if (o_pll_areset !== 1'b1) begin err_cnt++; $display("FAIL reset_pll_areset: got %0b exp 1", o_pll_areset); end
        chk_cnt++; if (o_chip_reset !== 1'b1) begin err_cnt++; $display("FAIL reset_chip_reset: got %0b exp 1", o_chip_reset); end
        chk_cnt++; if ({o_lock_fail, o_lock_lost} !== 2'b00) begin err_cnt++; $display("FAIL reset_flags: got %b exp 00", {o_lock_fail, o_lock_lost}); end
        chk_cnt++; if (o_retry_cnt !== 3'd0) begin err_cnt++; $display("FAIL reset_retry: got %0d exp 0", o_retry_cnt); end
    endtask

    // Lock rises 10 cycles after release; chip_reset falls 2+8+1 cycles later.
    task automatic test_clean_bringup();
        apply_reset();
        for (int k = 1; k <= 21; k++) begin
            tick();
            if (k == 3) begin
                chk_cnt++; if (o_pll_areset !== 1'b1) begin err_cnt++; $display("FAIL clean_pll_high_t3: got %0b exp 1", o_pll_areset); end
            end
            if (k == 4) begin
                chk_cnt++; if ({o_pll_areset, o_seq_state} !== 4'b0_001) begin err_cnt++; $display("FAIL clean_pll_fall_t4: got pll=%0b st=%0d exp pll=0 st=1", o_pll_areset, o_seq_state); end
            end
            if (k == 10) i_locked = 1'b1;
            if (k == 13) begin
                chk_cnt++; if (o_seq_state !== 3'd2) begin err_cnt++; $display("FAIL clean_stable_t13: got %0d exp 2", o_seq_state); end
            end
            if (k == 20) begin
                chk_cnt++; if (o_chip_reset !== 1'b1) begin err_cnt++; $display("FAIL clean_chip_rst_t20: got %0b exp 1", o_chip_reset); end
            end
        end
        chk_cnt++; if ({o_chip_reset, o_seq_state} !== 4'b0_011) begin err_cnt++; $display("FAIL clean_run_t21: got chip=%0b st=%0d exp chip=0 st=3", o_chip_reset, o_seq_state); end
        chk_cnt++; if ({o_pll_areset, o_retry_cnt} !== 4'b0_000) begin err_cnt++; $display("FAIL clean_pll_retry_t21: got pll=%0b retry=%0d exp 0/0", o_pll_areset, o_retry_cnt); end
    endtask

    // Starts in RUN. Lock drops, a new PLL reset pulse follows, then relock and re-release.
    task automatic test_lock_loss();
        i_locked = 1'b0;
        for (int k = 1; k <= 21; k++) begin
            tick();
            if (k == 2) begin
                chk_cnt++; if (o_chip_reset !== 1'b0) begin err_cnt++; $display("FAIL loss_chip_still_low_t2: got %0b exp 0", o_chip_reset); end
            end
            if (k == 3) begin
                chk_cnt++; if ({o_chip_reset, o_lock_lost, o_pll_areset} !== 3'b111) begin err_cnt++; $display("FAIL loss_detect_t3: got chip/lost/pll=%b exp 111", {o_chip_reset, o_lock_lost, o_pll_areset}); end
                chk_cnt++; if (o_seq_state !== 3'd0) begin err_cnt++; $display("FAIL loss_state_t3: got %0d exp 0", o_seq_state); end
            end
            if (k == 6) begin
                chk_cnt++; if (o_pll_areset !== 1'b1) begin err_cnt++; $display("FAIL loss_pll_high_t6: got %0b exp 1", o_pll_areset); end
            end
            if (k == 7) begin
                chk_cnt++; if ({o_pll_areset, o_seq_state} !== 4'b0_001) begin err_cnt++; $display("FAIL loss_pll_fall_t7: got pll=%0b st=%0d exp 0/1", o_pll_areset, o_seq_state); end
            end
            if (k == 10) i_locked = 1'b1;
            if (k == 20) begin
                chk_cnt++; if (o_chip_reset !== 1'b1) begin err_cnt++; $display("FAIL loss_chip_high_t20: got %0b exp 1", o_chip_reset); end
            end
        end
        chk_cnt++; if ({o_chip_reset, o_lock_lost, o_retry_cnt} !== 5'b0_1_000) begin err_cnt++; $display("FAIL loss_rerelease_t21: got chip=%0b lost=%0b retry=%0d exp 0/1/0", o_chip_reset, o_lock_lost, o_retry_cnt); end
    endtask

    // Starts in RUN with lock_lost set. sw_rst_req lands on the same cycle as the
    // second timeout, then again inside the resulting PLL reset window.
    task automatic test_sw_timeout();
        i_locked = 1'b0;
        for (int k = 1; k <= 81; k++) begin
            tick();
            i_sw_rst_req = 1'b0;
            if (k == 39) begin
                chk_cnt++; if ({o_seq_state, o_retry_cnt} !== 6'b000_001) begin err_cnt++; $display("FAIL swto_first_retry_t39: got st=%0d retry=%0d exp 0/1", o_seq_state, o_retry_cnt); end
            end
            if (k == 74) begin
                chk_cnt++; if ({o_seq_state, o_retry_cnt} !== 6'b001_001) begin err_cnt++; $display("FAIL swto_waiting_t74: got st=%0d retry=%0d exp 1/1", o_seq_state, o_retry_cnt); end
                i_sw_rst_req = 1'b1;
            end
            if (k == 75) begin
                chk_cnt++; if ({o_seq_state, o_retry_cnt} !== 6'b000_000) begin err_cnt++; $display("FAIL swto_restart_t75: got st=%0d retry=%0d exp 0/0", o_seq_state, o_retry_cnt); end
                chk_cnt++; if ({o_lock_lost, o_lock_fail, o_pll_areset} !== 3'b001) begin err_cnt++; $display("FAIL swto_flags_t75: got lost/fail/pll=%b exp 001", {o_lock_lost, o_lock_fail, o_pll_areset}); end
            end
            if (k == 76) i_sw_rst_req = 1'b1;
            if (k == 80) begin
                chk_cnt++; if ({o_pll_areset, o_seq_state} !== 4'b1_000) begin err_cnt++; $display("FAIL swto_window_restart_t80: got pll=%0b st=%0d exp 1/0", o_pll_areset, o_seq_state); end
            end
        end
        chk_cnt++; if ({o_pll_areset, o_seq_state} !== 4'b0_001) begin err_cnt++; $display("FAIL swto_window_end_t81: got pll=%0b st=%0d exp 0/1", o_pll_areset, o_seq_state); end
    endtask

    // Lock is high 5 cycles, low 1, then steady. STABLE falls back to WAIT_LOCK once.
    task automatic test_glitchy_lock();
        apply_reset();
        for (int k = 1; k <= 23; k++) begin
            tick();
            if (k == 6 || k == 12) i_locked = 1'b1;
            if (k == 11) i_locked = 1'b0;
            if (k == 13) begin
                chk_cnt++; if (o_seq_state !== 3'd2) begin err_cnt++; $display("FAIL glitch_stable_t13: got %0d exp 2", o_seq_state); end
            end
            if (k == 14) begin
                chk_cnt++; if (o_seq_state !== 3'd1) begin err_cnt++; $display("FAIL glitch_back_to_wait_t14: got %0d exp 1", o_seq_state); end
            end
            if (k == 15) begin
                chk_cnt++; if (o_seq_state !== 3'd2) begin err_cnt++; $display("FAIL glitch_restable_t15: got %0d exp 2", o_seq_state); end
            end
            if (k == 22) begin
                chk_cnt++; if (o_chip_reset !== 1'b1) begin err_cnt++; $display("FAIL glitch_chip_high_t22: got %0b exp 1", o_chip_reset); end
            end
        end
        chk_cnt++; if ({o_chip_reset, o_seq_state, o_retry_cnt} !== 7'b0_011_000) begin err_cnt++; $display("FAIL glitch_run_t23: got chip=%0b st=%0d retry=%0d exp 0/3/0", o_chip_reset, o_seq_state, o_retry_cnt); end
    endtask

    // Reset asserted in STABLE at cnt=5 takes effect without a clock edge.
    // Bring-up then restarts from PLL_RST with lock already present.
    task automatic test_async_reset_stable();
        apply_reset();
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 4) i_locked = 1'b1;
        end
        chk_cnt++; if (o_seq_state !== 3'd2) begin err_cnt++; $display("FAIL areset_in_stable_t12: got %0d exp 2", o_seq_state); end
        i_reset = 1'b1;
        #1;
        chk_cnt++; if ({o_seq_state, o_pll_areset, o_chip_reset, o_retry_cnt} !== 8'b000_1_1_000) begin err_cnt++; $display("FAIL areset_immediate: got st=%0d pll=%0b chip=%0b retry=%0d exp 0/1/1/0", o_seq_state, o_pll_areset, o_chip_reset, o_retry_cnt); end
        repeat (2) tick();
        i_reset = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            tick();
            if (k == 4) begin
                chk_cnt++; if ({o_pll_areset, o_seq_state} !== 4'b0_001) begin err_cnt++; $display("FAIL areset_restart_t4: got pll=%0b st=%0d exp 0/1", o_pll_areset, o_seq_state); end
            end
            if (k == 5) begin
                chk_cnt++; if (o_seq_state !== 3'd2) begin err_cnt++; $display("FAIL areset_restable_t5: got %0d exp 2", o_seq_state); end
            end
        end
        chk_cnt++; if ({o_chip_reset, o_seq_state} !== 4'b0_011) begin err_cnt++; $display("FAIL areset_run_t13: got chip=%0b st=%0d exp 0/3", o_chip_reset, o_seq_state); end
    endtask

    // Lock never arrives. The expected rise ticks of pll_areset are queued:
    // two retries, then the entry into FAIL.
    task automatic test_timeout_fail();
        logic prev_pll;
        logic [15:0] exp_tick;
        apply_reset();
        exp_q = {16'd36, 16'd72, 16'd108};
        prev_pll = o_pll_areset;
        for (int k = 1; k <= 115; k++) begin
            tick();
            if (o_pll_areset && !prev_pll) begin
                if (exp_q.size() == 0) begin
                    chk_cnt++; err_cnt++; $display("FAIL timeout_extra_pulse: got rise at tick %0d exp none", k);
                end else begin
                    exp_tick = exp_q.pop_front();
                    chk_cnt++; if (16'(k) !== exp_tick) begin err_cnt++; $display("FAIL timeout_pulse_rise: got tick %0d exp tick %0d", k, exp_tick); end
                end
            end
            prev_pll = o_pll_areset;
            if (k == 35 || k == 36 || k == 72) begin
                chk_cnt++; if (o_retry_cnt !== ((k == 35) ? 3'd0 : (k == 36) ? 3'd1 : 3'd2)) begin err_cnt++; $display("FAIL timeout_retry_t%0d: got %0d exp %0d", k, o_retry_cnt, (k == 35) ? 0 : (k == 36) ? 1 : 2); end
            end
            if (k == 107) begin
                chk_cnt++; if ({o_seq_state, o_lock_fail} !== 4'b001_0) begin err_cnt++; $display("FAIL timeout_before_fail_t107: got st=%0d fail=%0b exp 1/0", o_seq_state, o_lock_fail); end
            end
            if (k == 108) begin
                chk_cnt++; if ({o_seq_state, o_lock_fail, o_chip_reset, o_retry_cnt} !== 8'b100_1_1_010) begin err_cnt++; $display("FAIL timeout_fail_t108: got st=%0d fail=%0b chip=%0b retry=%0d exp 4/1/1/2", o_seq_state, o_lock_fail, o_chip_reset, o_retry_cnt); end
            end
        end
        chk_cnt++; if ({o_seq_state, o_pll_areset} !== 4'b100_1) begin err_cnt++; $display("FAIL timeout_fail_held_t115: got st=%0d pll=%0b exp 4/1", o_seq_state, o_pll_areset); end
        chk_cnt++; if (exp_q.size() != 0) begin err_cnt++; $display("FAIL timeout_missing_pulses: got %0d unseen exp 0", exp_q.size()); end
    endtask

    // Starts in FAIL. sw_rst_req clears the flags and gives a full 4-cycle PLL reset.
    task automatic test_sw_in_fail();
        i_sw_rst_req = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            i_sw_rst_req = 1'b0;
            if (k == 1) begin
                chk_cnt++; if ({o_seq_state, o_retry_cnt} !== 6'b000_000) begin err_cnt++; $display("FAIL swfail_state_t1: got st=%0d retry=%0d exp 0/0", o_seq_state, o_retry_cnt); end
                chk_cnt++; if ({o_lock_fail, o_lock_lost, o_pll_areset, o_chip_reset} !== 4'b0011) begin err_cnt++; $display("FAIL swfail_flags_t1: got fail/lost/pll/chip=%b exp 0011", {o_lock_fail, o_lock_lost, o_pll_areset, o_chip_reset}); end
            end
            if (k == 4) begin
                chk_cnt++; if (o_pll_areset !== 1'b1) begin err_cnt++; $display("FAIL swfail_pll_high_t4: got %0b exp 1", o_pll_areset); end
            end
        end
        chk_cnt++; if ({o_pll_areset, o_seq_state} !== 4'b0_001) begin err_cnt++; $display("FAIL swfail_pll_fall_t5: got pll=%0b st=%0d exp 0/1", o_pll_areset, o_seq_state); end
    endtask

    initial begin
        test_reset();
        test_clean_bringup();
        test_lock_loss();
        test_sw_timeout();
        test_glitchy_lock();
        test_async_reset_stable();
        test_timeout_fail();
        test_sw_in_fail();
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
